// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state codes and default width shared by alu_sequencer and alu_comb
package alu_seq_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOR = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational ALU, per-bit logic slices plus one adder shared by ADD/SUB/SLT/MUL
module alu_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             carry
);
  logic [WIDTH-1:0] and_v, or_v, xor_v, sum;
  logic sub, slt;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign and_v[i] = a[i] & b[i];
    assign or_v[i]  = a[i] | b[i];
    assign xor_v[i] = a[i] ^ b[i];
  end
  assign sub = op == OP_SUB || op == OP_SLT;
  assign {carry, sum} = {1'b0, a} + {1'b0, b ^ {WIDTH{sub}}} + (WIDTH+1)'(sub);
  // differing signs decide directly; equal signs cannot overflow, so the difference sign decides
  assign slt = (a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1];
  assign y = op == OP_AND ? and_v :
             op == OP_OR  ? or_v  :
             op == OP_XOR ? xor_v :
             op == OP_NOR ? ~or_v :
             op == OP_SLT ? {{(WIDTH-1){1'b0}}, slt} : sum;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready ALU controller; single-cycle ops and a WIDTH-step shift-add multiply
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_hi,
  output logic             rsp_zero
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0] state;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] mcand, alu_y;
  logic [CW-1:0] cnt;
  logic alu_c, in_mul;
  assign in_mul = state == ST_MUL;
  // the datapath serves the request in IDLE and the multiply's high-half accumulate in MUL
  alu_comb #(.WIDTH(WIDTH)) u_alu (
    .a    (in_mul ? prod[2*WIDTH-1:WIDTH] : req_a),
    .b    (in_mul ? mcand : req_b),
    .op   (in_mul ? OP_ADD : req_op),
    .y    (alu_y),
    .carry(alu_c)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      prod  <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          mcand <= req_a;
          cnt   <= '0;
          prod  <= {{WIDTH{1'b0}}, req_op == OP_MUL ? req_b : alu_y};
          state <= req_op == OP_MUL ? ST_MUL : ST_DONE;
        end
        ST_MUL: begin
          prod  <= prod[0] ? {alu_c, alu_y, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
          cnt   <= cnt == CW'(WIDTH - 1) ? '0 : cnt + CW'(1);
          state <= cnt == CW'(WIDTH - 1) ? ST_DONE : ST_MUL;
        end
        default: if (rsp_ready) state <= ST_IDLE;
      endcase
    end
  end
  assign req_ready  = state == ST_IDLE;
  assign rsp_valid  = state == ST_DONE;
  assign rsp_result = prod[WIDTH-1:0];
  assign rsp_hi     = prod[2*WIDTH-1:WIDTH];
  assign rsp_zero   = ~|prod[WIDTH-1:0];
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench with an arithmetic reference model and per-cycle scoreboard
module tb_alu_sequencer;
  import alu_seq_pkg::*;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, req_valid = 0, rsp_ready = 1;
  logic req_ready, rsp_valid, rsp_zero;
  logic [2:0] req_op = 0;
  logic [W-1:0] req_a = 0, req_b = 0, rsp_result, rsp_hi;
  int checks = 0, failures = 0, cyc = 0, rsp_cnt = 0;
  bit b2b = 0, shown = 0, b2b_seen = 0;
  int last_acc = 0;
  typedef struct {
    logic [2*W-1:0] prod;
    int due;
  } exp_t;
  exp_t q[$];
  logic [2:0]   v_op[8] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_SUB, OP_SLT, OP_ADD};
  logic [W-1:0] v_a[8]  = '{32'h12345678, 32'h12340000, 32'hFFFF0000, 32'h0F0F0F0F,
                            32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hA5A5A5A5};
  logic [W-1:0] v_b[8]  = '{32'h0F0F0F0F, 32'h00005678, 32'h0FF00FF0, 32'hF0F0F0F0,
                            32'h00000001, 32'h00000001, 32'h00000000, 32'h5A5A5A5B};

  alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_hi(rsp_hi), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] s;
    case (op)
      OP_AND:  s = a & b;
      OP_OR:   s = a | b;
      OP_XOR:  s = a ^ b;
      OP_NOR:  s = ~(a | b);
      OP_ADD:  s = a + b;
      OP_SUB:  s = a - b;
      OP_SLT:  s = ($signed(a) < $signed(b)) ? 1 : 0;
      default: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endcase
    return {{W{1'b0}}, s};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      shown = 0;
    end else begin
      if (q.size() > 0 && !shown && q[0].due == cyc) check("rsp_on_time", rsp_valid, 1);
      if (rsp_valid) begin
        check("rsp_has_req", q.size() > 0, 1);
        if (q.size() > 0) begin
          if (!shown) check("rsp_latency", cyc, q[0].due);
          check("rsp_result", rsp_result, q[0].prod[W-1:0]);
          check("rsp_hi", rsp_hi, q[0].prod[2*W-1:W]);
          check("rsp_zero", rsp_zero, q[0].prod[W-1:0] == 0);
          check("ready_low_in_rsp", req_ready, 0);
          shown = 1;
          if (rsp_ready) begin
            void'(q.pop_front());
            shown = 0;
            rsp_cnt++;
          end
        end
      end
      if (req_valid && req_ready) begin
        if (b2b && b2b_seen) check("b2b_issue_gap", cyc - last_acc, 2);
        b2b_seen = b2b;
        last_acc = cyc;
        q.push_back('{model(req_op, req_a, req_b), cyc + (req_op == OP_MUL ? W + 1 : 1)});
      end
    end
  end

  task automatic issue(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, bit keep);
    int n;
    @(posedge clk); #1;
    req_op = op; req_a = a; req_b = b; req_valid = 1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    check("issue_accepted", n < 100, 1);
    @(posedge clk); #1;
    if (!keep) req_valid = 0;
  endtask

  task automatic wait_rsp(output logic [W-1:0] res, output logic [W-1:0] hi, output logic z,
                          output int w);
    for (w = 1; w <= 200; w++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    check("rsp_arrived", w <= 200, 1);
    res = rsp_result; hi = rsp_hi; z = rsp_zero;
  endtask

  task automatic run(string name, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                     logic [W-1:0] lo_e, logic [W-1:0] hi_e, int lat_e);
    logic [W-1:0] r, h;
    logic z;
    int w;
    issue(op, a, b, 0);
    wait_rsp(r, h, z, w);
    check({name, "_lo"}, r, lo_e);
    check({name, "_hi"}, h, hi_e);
    check({name, "_zero"}, z, lo_e == 0);
    check({name, "_latency"}, w, lat_e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r, h;
    logic z;
    int w, base;
    repeat (3) @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_ready", req_ready, 1);
    check("rst_result", rsp_result, 0);
    check("rst_hi", rsp_hi, 0);
    check("rst_zero", rsp_zero, 1);
    @(posedge clk); #1 rst_n = 1;
    issue(OP_MUL, 32'h12345678, 32'h9ABCDEF1, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midmul_rst_result", rsp_result, 0);
    check("midmul_rst_hi", rsp_hi, 0);
    check("midmul_rst_zero", rsp_zero, 1);
    check("midmul_rst_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_valid", rsp_valid, 0);
    run("and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1);
    run("nor", OP_NOR, 32'h0000FFFF, 32'h00FF00FF, 32'hFF000000, 0, 1);
    run("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 1);
    run("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 1);
    run("slt_neg", OP_SLT, 32'h80000000, 32'h00000001, 32'h00000001, 0, 1);
    run("slt_pos", OP_SLT, 32'h00000001, 32'h80000000, 32'h00000000, 0, 1);
    run("mul_max", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, W + 1);
    run("mul_pow", OP_MUL, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, W + 1);
    run("mul_small", OP_MUL, 32'd12345, 32'd6789, 32'd83810205, 0, W + 1);
    @(posedge clk); #1 rsp_ready = 0;
    issue(OP_ADD, 32'd100, 32'd23, 0);
    wait_rsp(r, h, z, w);
    check("bp_first_lo", r, 123);
    @(posedge clk); #1;
    req_op = OP_XOR; req_a = 32'h0F0F0F0F; req_b = 32'h00FF00FF; req_valid = 1;
    repeat (20) @(negedge clk);
    check("bp_valid_held", rsp_valid, 1);
    check("bp_ready_low", req_ready, 0);
    check("bp_lo_held", rsp_result, 123);
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    check("bp_retire_cycle_valid", rsp_valid, 1);
    @(negedge clk);
    check("bp_ready_after_retire", req_ready, 1);
    check("bp_valid_after_retire", rsp_valid, 0);
    @(posedge clk); #1 req_valid = 0;
    wait_rsp(r, h, z, w);
    check("bp_held_req_lo", r, 32'h0FF00FF0);
    check("bp_held_req_latency", w, 1);
    @(posedge clk); #1;
    b2b = 1;
    base = rsp_cnt;
    for (int i = 0; i < 8; i++) issue(v_op[i], v_a[i], v_b[i], i < 7);
    repeat (6) @(negedge clk);
    check("b2b_rsp_count", rsp_cnt - base, 8);
    check("b2b_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that accepts ALU operation requests over a valid/ready handshake, executes single-cycle ops (AND, OR, XOR, NOR, ADD, SUB, SLT) through the combinational ALU datapath, and sequences a WIDTH-iteration shift-add unsigned multiply over that same datapath's adder. It sits between the instruction/control logic and the bitwise/arith ALU slices. It holds each result until the consumer accepts it.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT, 111 MUL
- req_a  input  WIDTH  operand A
- req_b  input  WIDTH  operand B
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer accepts result
- rsp_result  output  WIDTH  result (low half for MUL)
- rsp_hi  output  WIDTH  high half of MUL product; 0 for all other ops
- rsp_zero  output  1  rsp_result == 0

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE: req_ready=1. On req_valid: latch op/operands.
  - Non-MUL op: compute, register the result, go to DONE.
  - MUL: load product = {WIDTH'0, req_b} and multiplicand = req_a, clear iteration counter, go to MUL.
- MUL, one iteration per cycle: if product[0], add multiplicand to product[2W-1:W] with carry-out c. Then shift product right by 1, inserting c at bit 2W-1. After iteration WIDTH-1 (counter wraps), go to DONE.
- DONE: rsp_valid=1; rsp_result/rsp_hi/rsp_zero stable. On rsp_ready go to IDLE.
- req_ready=0 in MUL and DONE. Requests arriving then are ignored and must be held by the requester.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT is signed two's-complement; result 1 or 0, zero-extended.
  - MUL is unsigned; full 2·WIDTH product in {rsp_hi, rsp_result}.
- Reset (any state, including mid-MUL): state=IDLE, counter=0, rsp_result=0, rsp_hi=0, rsp_zero=1, rsp_valid=0, req_ready=1 once rst_n deasserts. A partial product is discarded.
- Operand changes on req_* after acceptance have no effect.

## Timing
- Accept at rising edge k (req_valid & req_ready).
- Non-MUL: rsp_valid=1 from edge k+1 (latency 1).
- MUL: rsp_valid=1 from edge k+1+WIDTH (latency WIDTH+1; 33 for WIDTH=32).
- Response retire at edge j (rsp_valid & rsp_ready): rsp_valid=0 and req_ready=1 from edge j+1. Minimum issue interval: 2 cycles non-MUL, WIDTH+2 cycles MUL.
- No same-cycle retire-and-accept (req_ready is 0 during DONE).
- rsp_ready held 1 throughout: response still appears for exactly one cycle.
- All outputs registered or decoded from registered state only; no combinational path from req_* or rsp_ready to any output.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams (OP_AND … OP_MUL, 3-bit)
  - FSM state enum (IDLE, MUL, DONE)
  - default WIDTH constant
- Sub-module alu_comb: purely combinational. Inputs a, b, op; output WIDTH-bit result built from per-bit gate slices plus a WIDTH-bit adder with carry-out.
- alu_comb is reused by alu_sequencer for MUL iterations (ADD op on the high half plus multiplicand).

## Test plan
- Reset mid-MUL: issue MUL, assert rst_n=0 at iteration 10 → outputs zero, rsp_zero=1, req_ready=1 after release. A subsequent AND 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000 at latency 1.
- Logic/arith sweep:
  - NOR 0x0000FFFF, 0x00FF00FF → 0xFF000000
  - ADD 0xFFFFFFFF + 1 → 0x00000000, rsp_zero=1
  - SUB 5 − 7 → 0xFFFFFFFE
  - SLT 0x80000000 vs 1 → 1
- MUL 0xFFFFFFFF × 0xFFFFFFFF → rsp_hi=0xFFFFFFFE, rsp_result=0x00000001, rsp_valid exactly 33 cycles after accept.
- MUL 0x00010000 × 0x00010000 → rsp_hi=0x00000001, rsp_result=0.
- Backpressure: hold rsp_ready=0 for 20 cycles after the result. Outputs stay stable, req_ready=0, and a concurrent req_valid is not consumed. Release → retire, next request accepted one cycle later.
- Back-to-back: rsp_ready and req_valid both tied high with 8 random non-MUL requests → exactly one response per 2 cycles, results match a reference model, none dropped or duplicated.
